// File: rtl/exec_step_controller.sv
// -----------------------------------------------------------------------------
// exec_step_controller
//
// Sequences the multicycle MIPS core from outside the core. The control FSM
// sits in its pre-fetch state (cpu_idle high) until this block pulses `go`,
// which feeds the control unit's botton_State input. Three operating styles
// are offered: free run, single step and halt on a PC breakpoint. Two raw push
// buttons are synchronised, debounced and turned into one-cycle press events
// that move the sequencer between its modes. Every issued instruction is
// counted for the board LEDs and the debug display.
//
// Ports
//   clk           clock
//   Reset         synchronous, active-high reset
//   btn_step      raw asynchronous step button
//   btn_run       raw asynchronous run/halt toggle button
//   cpu_idle      high while the control FSM waits in pre-fetch
//   pc            current PC (address of the next instruction while idle)
//   bp_enable     breakpoint compare enable
//   bp_addr       breakpoint address
//   go            registered one-cycle start pulse to the control FSM
//   mode          00 HALT, 01 STEP_WAIT, 10 RUN, 11 BP_HALT
//   halted_at_bp  high while stopped on a breakpoint
//   instr_count   number of go pulses issued, wraps to 0
// -----------------------------------------------------------------------------
module exec_step_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned PC_WIDTH        = 32,
   parameter int unsigned ICOUNT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    Reset,
   input  logic                    btn_step,
   input  logic                    btn_run,
   input  logic                    cpu_idle,
   input  logic [PC_WIDTH-1:0]     pc,
   input  logic                    bp_enable,
   input  logic [PC_WIDTH-1:0]     bp_addr,
   output logic                    go,
   output logic [1:0]              mode,
   output logic                    halted_at_bp,
   output logic [ICOUNT_WIDTH-1:0] instr_count
);

   // --------------------------------------------------------------------------
   // Button front end. Index 0 is the step button, index 1 the run button.
   // --------------------------------------------------------------------------
   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   logic [1:0]      btn_raw;
   logic [1:0]      sync1_q;
   logic [1:0]      sync2_q;
   logic [1:0]      level_q;
   logic [1:0]      level_d;
   logic [1:0]      level_prev_q;
   logic [1:0]      press_q;
   logic [CntW-1:0] cnt_q [2];
   logic [CntW-1:0] cnt_d [2];

   assign btn_raw = {btn_run, btn_step};

   // The counter measures how long the synchronised input has disagreed with
   // the debounced level; any agreement restarts the measurement.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         cnt_d[i]   = '0;
         level_d[i] = level_q[i];
         if (sync2_q[i] != level_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               level_d[i] = ~level_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CntOne;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         level_q      <= '0;
         level_prev_q <= '0;
         press_q      <= '0;
         cnt_q[0]     <= '0;
         cnt_q[1]     <= '0;
      end else begin
         sync1_q      <= btn_raw;
         sync2_q      <= sync1_q;
         level_q      <= level_d;
         level_prev_q <= level_q;
         // Registered edge detect: one-cycle event one cycle after the flip.
         press_q      <= level_q & ~level_prev_q;
         cnt_q[0]     <= cnt_d[0];
         cnt_q[1]     <= cnt_d[1];
      end
   end

   logic press_step;
   logic press_run;

   assign press_step = press_q[0];
   assign press_run  = press_q[1];

   // --------------------------------------------------------------------------
   // Sequencer FSM
   // --------------------------------------------------------------------------
   typedef enum logic [1:0] {
      StHalt     = 2'b00,
      StStepWait = 2'b01,
      StRun      = 2'b10,
      StBpHalt   = 2'b11
   } state_e;

   state_e                  state_q;
   state_e                  state_d;
   logic                    go_q;
   logic                    issue;
   logic                    bp_skip_q;
   logic                    bp_skip_d;
   logic [ICOUNT_WIDTH-1:0] instr_count_q;

   localparam logic [ICOUNT_WIDTH-1:0] CountOne = ICOUNT_WIDTH'(1);

   logic issue_ok;
   logic bp_hit;

   // go_q guards the cycle between the pulse and cpu_idle falling, so the
   // core can never see two back-to-back pulses.
   assign issue_ok = cpu_idle & ~go_q;
   assign bp_hit   = bp_enable & (pc == bp_addr) & ~bp_skip_q;

   // State register
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q       <= StHalt;
         go_q          <= 1'b0;
         bp_skip_q     <= 1'b0;
         instr_count_q <= '0;
      end else begin
         state_q   <= state_d;
         go_q      <= issue;
         bp_skip_q <= bp_skip_d;
         if (issue) begin
            instr_count_q <= instr_count_q + CountOne;
         end
      end
   end

   // Next-state logic. press_run is always tested first so it wins over a
   // simultaneous press_step.
   always_comb begin
      state_d   = state_q;
      issue     = 1'b0;
      bp_skip_d = bp_skip_q;
      unique case (state_q)
         StHalt: begin
            if (press_run) begin
               state_d = StRun;
            end else if (press_step) begin
               state_d = StStepWait;
            end
         end
         StStepWait: begin
            // Extra step presses while waiting are dropped, not queued.
            if (press_run) begin
               state_d = StRun;
            end else if (issue_ok) begin
               issue   = 1'b1;
               state_d = StHalt;
            end
         end
         StRun: begin
            // Halting only stops further issues; an instruction already
            // started runs to completion in the core.
            if (press_run) begin
               state_d = StHalt;
            end else if (issue_ok) begin
               if (bp_hit) begin
                  state_d = StBpHalt;
               end else begin
                  issue     = 1'b1;
                  bp_skip_d = 1'b0;
               end
            end
         end
         StBpHalt: begin
            // Resuming from a breakpoint must not re-trigger on the same PC.
            if (press_run) begin
               bp_skip_d = 1'b1;
               state_d   = StRun;
            end else if (press_step) begin
               state_d = StStepWait;
            end
         end
      endcase
   end

   // Output logic
   always_comb begin
      go           = go_q;
      mode         = state_q;
      halted_at_bp = (state_q == StBpHalt);
      instr_count  = instr_count_q;
   end

endmodule
